complemento2_serial: RTL

Parametrised, bit-serial complement unit: accepts a WIDTH-bit word on a start pulse and returns its one's or two's complement after WIDTH clock cycles, one bit per cycle, LSB first. It is the sequential, width-generic successor of the combinational 6-bit negator. It trades the WIDTH-stage adder chain for one full-adder slice plus a shift register. It sits beside the datapath wherever a negated operand is needed and latency is acceptable, and signals completion with a one-cycle done pulse.

---
 rtl/complemento2_serial_if.sv | 24 ++
 rtl/complemento2_serial.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/complemento2_serial_if.sv
// Request/result bundle for the bit-serial complement unit.
// The master drives the operand and start; the slave returns the status and result.
interface complemento2_serial_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resultado;
  logic             carryOut;
  logic             overflow;

  modport master (
    output start, mode, a,
    input  busy, done, resultado, carryOut, overflow
  );

  modport slave (
    input  start, mode, a,
    output busy, done, resultado, carryOut, overflow
  );
endinterface

// File: rtl/complemento2_serial.sv
// Bit-serial one's/two's complement unit.
// A single full-adder slice walks the captured operand LSB first. Each sum bit
// enters the accumulator from the MSB side, so after WIDTH steps the word is
// aligned. The result, carry and overflow are published together on entry to
// DONE and are held otherwise.
module complemento2_serial #(
  parameter int WIDTH = 6
) (
  input logic                 clk,
  input logic                 reset,
  complemento2_serial_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] opnd_r, opnd_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] res_r, res_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             carry_r, carry_s;
  logic             ovf_pend_r, ovf_pend_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             co_r, co_s;
  logic             ovf_r, ovf_s;
  logic             accept_s;
  logic             sum_s;
  logic             carry_nx_s;

  // Most negative two's complement value: its negation wraps back onto itself.
  function automatic logic most_negative(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] & (v[WIDTH-2:0] == {(WIDTH-1){1'b0}});
  endfunction

  // Next-state, datapath and output decode; every register holds unless changed below.
  always_comb begin
    state_s    = state_r;
    opnd_s     = opnd_r;
    acc_s      = acc_r;
    res_s      = res_r;
    cnt_s      = cnt_r;
    carry_s    = carry_r;
    ovf_pend_s = ovf_pend_r;
    busy_s     = busy_r;
    done_s     = done_r;
    co_s       = co_r;
    ovf_s      = ovf_r;
    accept_s   = 1'b0;

    sum_s      = (~opnd_r[0]) ^ carry_r;
    carry_nx_s = (~opnd_r[0]) & carry_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
        end else begin
          busy_s = 1'b0;
          done_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        acc_s   = {sum_s, acc_r[WIDTH-1:1]};
        opnd_s  = {1'b0, opnd_r[WIDTH-1:1]};
        carry_s = carry_nx_s;
        cnt_s   = cnt_r + CW'(1);
        if (cnt_r == CW'(WIDTH - 1)) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          res_s   = {sum_s, acc_r[WIDTH-1:1]};
          co_s    = carry_nx_s;
          ovf_s   = ovf_pend_r;
        end else begin
          busy_s = 1'b1;
          done_s = 1'b0;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase

    // A request accepted in IDLE or DONE restarts the slice from bit 0.
    // Mode seeds the carry, which is how two's complement adds its +1.
    if (accept_s) begin
      state_s    = ST_SHIFT;
      opnd_s     = bus.a;
      acc_s      = {WIDTH{1'b0}};
      carry_s    = bus.mode;
      cnt_s      = {CW{1'b0}};
      ovf_pend_s = bus.mode & most_negative(bus.a);
      busy_s     = 1'b1;
      done_s     = 1'b0;
    end else begin
      accept_s = 1'b0;
    end
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      opnd_r     <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      res_r      <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      carry_r    <= 1'b0;
      ovf_pend_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      co_r       <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      opnd_r     <= opnd_s;
      acc_r      <= acc_s;
      res_r      <= res_s;
      cnt_r      <= cnt_s;
      carry_r    <= carry_s;
      ovf_pend_r <= ovf_pend_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      co_r       <= co_s;
      ovf_r      <= ovf_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.resultado = res_r;
  assign bus.carryOut  = co_r;
  assign bus.overflow  = ovf_r;

endmodule
